subpel_conv_seq: RTL and testbench
==================================

Name: subpel_conv_seq

Overview:
Sequential, resource-shared successor to the combinational sub-pixel upsampler. It performs a KxK zero-padded 2D convolution producing OUT_CHANNELS*R*R channels with a single time-multiplexed MAC. Each result is written directly into its pixel-shuffled position of the upscaled output tensor. It adds fixed-point rescaling, signed saturation with a sticky flag, a runtime ReLU mode and a start/busy/done handshake, and sits in the decoder upsampling path.

Parameters:
IN_CHANNELS, 2, input channel count
OUT_CHANNELS, 1, output channel count after shuffle
IN_HEIGHT, 4, input rows
IN_WIDTH, 4, input columns
R, 2, upscale factor (>=1)
KERNEL_SIZE, 3, odd kernel size K; padding P=K/2, stride 1
DATA_WIDTH, 16, signed two's-complement element width DW
FRAC_BITS, 0, fractional bits of weights; result is arithmetic-shifted right by FRAC_BITS

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; accepted only in IDLE
relu_en  in  1  ReLU mode; sampled on start acceptance
input_tensor_flat  in  IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DW  element [ci][h][w] at index (ci*H+h)*W+w; stable while busy
conv_weights_flat  in  CO*IN_CHANNELS*K*K*DW  CO=OUT_CHANNELS*R*R; element [co][ci][kh][kw] at ((co*IN_CHANNELS+ci)*K+kh)*K+kw
conv_bias_flat  in  CO*DW  bias [co]
busy  out  1  high while a run is in progress
done  out  1  one-cycle pulse at run completion
sat_flag  out  1  sticky: some element of the current/last run saturated
output_tensor_flat  out  OUT_CHANNELS*(H*R)*(W*R)*DW  element [c][y][x] at (c*H*R+y)*W*R+x

Behaviour:
- Reset (async, any time incl. mid-run): state=IDLE, busy=0, done=0, sat_flag=0, output_tensor_flat=0, all counters/accumulator=0. Partial results are discarded.
- States: IDLE -> LOAD -> MAC -> WRITE -> (LOAD | DONE) -> IDLE.
- IDLE: on start=1, latch relu_en, clear sat_flag, zero all counters, busy<=1, go to LOAD. start is ignored in every other state.
- Element order: co outer, then h, then w. E=CO*H*W elements; N=IN_CHANNELS*K*K taps per element.
- LOAD (1 cycle): acc <= sign-extended bias[co] << FRAC_BITS.
- MAC (N cycles): tap order ci, kh, kw. acc += x*wt. x = input[ci][h+kh-P][w+kw-P], or 0 if out of bounds. The product is full 2*DW signed. acc width is 2*DW+clog2(N)+1 and must never wrap.
- WRITE (1 cycle):
  - v = acc >>> FRAC_BITS.
  - If v > 2^(DW-1)-1 or v < -2^(DW-1), clamp and set sat_flag.
  - If latched relu_en and v<0, v=0. ReLU is applied after clamp; a negative clamp still sets sat_flag.
  - Write v to output [c][h*R+r1][w*R+r2], where co = c*R*R + r1*R + r2.
  - If not last element go to LOAD; else go to DONE.
- Transition from the last WRITE: done<=1, busy<=0. DONE lasts 1 cycle (done=1), then IDLE with done<=0.
- Latency: with the start-accept edge counted as edge 0, done is high after edge E*(N+2). Total is E*(N+2) cycles.
- Unwritten output elements keep their prior values during a run. Outputs are only cleared by reset.
- Input changes mid-run are not supported; the result for affected elements is undefined.

Test Plan:
- Defaults; all inputs=1, weights=1, bias=0, relu_en=0 -> output 8x8 with corner 2x2 blocks=8, edge blocks=12, interior=18; done exactly 1280 cycles after start; sat_flag=0.
- Weights=0, bias[co]=co -> every output pixel (y,x) equals (y%2)*2+(x%2), checking shuffle ordering.
- Inputs=1, weights=-1 (0xFFFF), bias=0 -> interior 0xFFEE (-18) with relu_en=0; rerun with relu_en=1 -> all outputs 0, sat_flag=0.
- Inputs=0x7FFF, weights=0x7FFF -> all outputs 0x7FFF, sat_flag=1. A next run with unit data clears sat_flag on start acceptance.
- FRAC_BITS=8 build; inputs=0x0100, weights=0x0080 (0.5), bias=0 -> interior output = 18*0x80 = 0x0900.
- Assert start while busy at cycle 100 -> ignored, done still at 1280. Assert rst at cycle 600 -> busy=0, outputs=0 immediately; a fresh start then completes normally.

Source files
------------

// File: rtl/subpel_conv_if.sv
// subpel_conv_if: start/busy/done handshake and tensor buses of the sub-pixel convolution upsampler
interface subpel_conv_if #(
  parameter int IN_CHANNELS  = 2,
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int R            = 2,
  parameter int KERNEL_SIZE  = 3,
  parameter int DATA_WIDTH   = 16
);
  localparam int CO = OUT_CHANNELS * R * R;
  logic start;
  logic relu_en;
  logic busy;
  logic done;
  logic sat_flag;
  logic [IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0] input_tensor_flat;
  logic [CO*IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] conv_weights_flat;
  logic [CO*DATA_WIDTH-1:0] conv_bias_flat;
  logic [OUT_CHANNELS*IN_HEIGHT*R*IN_WIDTH*R*DATA_WIDTH-1:0] output_tensor_flat;
  modport master (
    output start, relu_en, input_tensor_flat, conv_weights_flat, conv_bias_flat,
    input  busy, done, sat_flag, output_tensor_flat
  );
  modport slave (
    input  start, relu_en, input_tensor_flat, conv_weights_flat, conv_bias_flat,
    output busy, done, sat_flag, output_tensor_flat
  );
endinterface

// File: rtl/subpel_conv_seq.sv
// subpel_conv_seq: single-MAC KxK convolution writing each result straight into its pixel-shuffled slot
module subpel_conv_seq #(
  parameter int IN_CHANNELS  = 2,
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int R            = 2,
  parameter int KERNEL_SIZE  = 3,
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 0
) (
  input logic clk,
  input logic rst,
  subpel_conv_if.slave bus
);
  localparam int K  = KERNEL_SIZE;
  localparam int P  = K / 2;
  localparam int DW = DATA_WIDTH;
  localparam int H  = IN_HEIGHT;
  localparam int W  = IN_WIDTH;
  localparam int IC = IN_CHANNELS;
  localparam int CO = OUT_CHANNELS * R * R;
  localparam int N  = IC * K * K;
  localparam int AW = 2 * DW + $clog2(N) + 1;
  localparam int OW = OUT_CHANNELS * H * R * W * R * DW;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] MAC   = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = -MAXV - 1;
  logic [2:0] state;
  int co, h, w, ci, kh, kw;
  logic relu_q, busy_q, done_q, sat_q;
  logic signed [AW-1:0] acc;
  logic [OW-1:0] out_q;
  int ih, iw, xi, oi;
  logic inb, sat, last_tap, last_elem;
  logic signed [DW-1:0] x, wt, b, yc, y;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0] v;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sat_flag = sat_q;
  assign bus.output_tensor_flat = out_q;
  // tap fetch with zero padding, product, rescale/clamp/ReLU and shuffled destination index
  always_comb begin
    ih = h + kh - P;
    iw = w + kw - P;
    inb = ih >= 0 && ih < H && iw >= 0 && iw < W;
    xi = inb ? (ci * H + ih) * W + iw : 0;
    x = inb ? bus.input_tensor_flat[xi*DW +: DW] : '0;
    wt = bus.conv_weights_flat[(((co * IC + ci) * K + kh) * K + kw)*DW +: DW];
    b = bus.conv_bias_flat[co*DW +: DW];
    prod = (2*DW)'(x) * (2*DW)'(wt);
    v = acc >>> FRAC_BITS;
    sat = v > MAXV || v < MINV;
    yc = v > MAXV ? MAXV[DW-1:0] : v < MINV ? MINV[DW-1:0] : v[DW-1:0];
    y = relu_q && yc[DW-1] ? '0 : yc;
    oi = ((co / (R * R)) * H * R + h * R + (co % (R * R)) / R) * W * R + w * R + co % R;
    last_tap = ci == IC - 1 && kh == K - 1 && kw == K - 1;
    last_elem = co == CO - 1 && h == H - 1 && w == W - 1;
  end
  // control FSM, tap/element counters, accumulator and output tensor
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      {co, h, w, ci, kh, kw} <= '0;
      acc <= '0;
      relu_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sat_q <= 1'b0;
      out_q <= '0;
    end else
      case (state)
        IDLE:
          if (bus.start) begin
            relu_q <= bus.relu_en;
            sat_q <= 1'b0;
            {co, h, w, ci, kh, kw} <= '0;
            busy_q <= 1'b1;
            state <= LOAD;
          end
        LOAD: begin
          acc <= AW'(b) <<< FRAC_BITS;
          state <= MAC;
        end
        MAC: begin
          acc <= acc + AW'(prod);
          kw <= kw == K - 1 ? 0 : kw + 1;
          kh <= kw == K - 1 ? (kh == K - 1 ? 0 : kh + 1) : kh;
          ci <= kw == K - 1 && kh == K - 1 ? (ci == IC - 1 ? 0 : ci + 1) : ci;
          state <= last_tap ? WRITE : MAC;
        end
        WRITE: begin
          out_q[oi*DW +: DW] <= y;
          sat_q <= sat_q | sat;
          w <= w == W - 1 ? 0 : w + 1;
          h <= w == W - 1 ? (h == H - 1 ? 0 : h + 1) : h;
          co <= w == W - 1 && h == H - 1 ? (co == CO - 1 ? 0 : co + 1) : co;
          busy_q <= !last_elem;
          done_q <= last_elem;
          state <= last_elem ? DONE : LOAD;
        end
        DONE: begin
          done_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_subpel_conv_seq.sv
// tb_subpel_conv_seq: table-driven directed checks of the sequential sub-pixel upsampler
module tb_subpel_conv_seq;
  localparam int DW = 16, IC = 2, H = 4, W = 4, K = 3, CO = 4;
  localparam int IW = IC * H * W * DW, WW = CO * IC * K * K * DW, BW = CO * DW, OW = 64 * DW;
  typedef struct {
    logic [15:0] in_v;
    logic [15:0] wt_v;
    int bm;
    logic relu;
    int ec, ee, ei;
    logic sat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0, checks = 0, lat;
  vec_t tbl[9];
  logic [IW-1:0] it;
  logic [WW-1:0] wf;
  logic [BW-1:0] bf;
  always #5 clk = ~clk;
  subpel_conv_if a();
  subpel_conv_if b();
  subpel_conv_seq dut (.clk(clk), .rst(rst), .bus(a.slave));
  subpel_conv_seq #(.FRAC_BITS(8)) dut8 (.clk(clk), .rst(rst), .bus(b.slave));
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic make(input logic [15:0] iv, input logic [15:0] wv, input int bm,
                      output logic [IW-1:0] ti, output logic [WW-1:0] tw, output logic [BW-1:0] tb);
    for (int i = 0; i < IC * H * W; i++) ti[i*DW +: DW] = iv;
    for (int i = 0; i < CO * IC * K * K; i++) tw[i*DW +: DW] = wv;
    for (int c = 0; c < CO; c++) tb[c*DW +: DW] = DW'(bm * c);
  endtask
  task automatic check_out(input string nm, input logic [OW-1:0] o, input int ec, input int ee, input int ei, input int bm);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        int nb, e;
        nb = int'(y / 2 == 0 || y / 2 == 3) + int'(x / 2 == 0 || x / 2 == 3);
        e = (nb == 2 ? ec : nb == 1 ? ee : ei) + bm * ((y % 2) * 2 + x % 2);
        chk($sformatf("%s px(%0d,%0d)", nm, y, x), int'($signed(o[(y*8+x)*DW +: DW])), e);
      end
  endtask
  task automatic load_a(input int i);
    make(tbl[i].in_v, tbl[i].wt_v, tbl[i].bm, it, wf, bf);
    a.input_tensor_flat = it;
    a.conv_weights_flat = wf;
    a.conv_bias_flat = bf;
  endtask
  task automatic run_a(input logic rl, input int glitch, output int n);
    @(negedge clk);
    a.relu_en = rl;
    a.start = 1'b1;
    @(posedge clk);
    #1 a.start = 1'b0;
    chk("busy after accept", int'(a.busy), 1);
    chk("sat cleared on accept", int'(a.sat_flag), 0);
    n = 0;
    while (!a.done && n < 2000) begin
      @(posedge clk);
      #1 n++;
      a.start = n == glitch;
    end
    a.start = 1'b0;
    chk("done latency", n, 1280);
    chk("busy low at done", int'(a.busy), 0);
    @(posedge clk);
    #1 chk("done one cycle", int'(a.done), 0);
  endtask
  initial begin
    a.start = 0; a.relu_en = 0; a.input_tensor_flat = '0; a.conv_weights_flat = '0; a.conv_bias_flat = '0;
    b.start = 0; b.relu_en = 0; b.input_tensor_flat = '0; b.conv_weights_flat = '0; b.conv_bias_flat = '0;
    tbl[0] = '{16'h0001, 16'h0001, 0, 1'b0, 8, 12, 18, 1'b0};
    tbl[1] = '{16'h0001, 16'h0000, 1, 1'b0, 0, 0, 0, 1'b0};
    tbl[2] = '{16'h0001, 16'hFFFF, 0, 1'b0, -8, -12, -18, 1'b0};
    tbl[3] = '{16'h0001, 16'hFFFF, 0, 1'b1, 0, 0, 0, 1'b0};
    tbl[4] = '{16'h7FFF, 16'h7FFF, 0, 1'b0, 32767, 32767, 32767, 1'b1};
    tbl[5] = '{16'h0001, 16'h0001, 0, 1'b0, 8, 12, 18, 1'b0};
    tbl[6] = '{16'h7FFF, 16'h8001, 0, 1'b0, -32768, -32768, -32768, 1'b1};
    tbl[7] = '{16'h7FFF, 16'h8001, 0, 1'b1, 0, 0, 0, 1'b1};
    tbl[8] = '{16'h0003, 16'hFFFE, 5, 1'b0, -48, -72, -108, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", int'(a.busy), 0);
    chk("reset done", int'(a.done), 0);
    chk("reset sat", int'(a.sat_flag), 0);
    chk("reset out nonzero", int'(a.output_tensor_flat != '0), 0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      load_a(i);
      run_a(tbl[i].relu, -1, lat);
      chk($sformatf("vec%0d sat", i), int'(a.sat_flag), int'(tbl[i].sat));
      check_out($sformatf("vec%0d", i), a.output_tensor_flat, tbl[i].ec, tbl[i].ee, tbl[i].ei, tbl[i].bm);
    end
    load_a(0);
    run_a(1'b0, 100, lat);
    check_out("start while busy", a.output_tensor_flat, 8, 12, 18, 0);
    @(negedge clk);
    a.start = 1'b1;
    @(posedge clk);
    #1 a.start = 1'b0;
    repeat (600) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrun rst busy", int'(a.busy), 0);
    chk("midrun rst done", int'(a.done), 0);
    chk("midrun rst out nonzero", int'(a.output_tensor_flat != '0), 0);
    @(negedge clk);
    rst = 1'b0;
    run_a(1'b0, -1, lat);
    check_out("after rst", a.output_tensor_flat, 8, 12, 18, 0);
    make(16'h0100, 16'h0080, 0, it, wf, bf);
    b.input_tensor_flat = it;
    b.conv_weights_flat = wf;
    b.conv_bias_flat = bf;
    @(negedge clk);
    b.start = 1'b1;
    @(posedge clk);
    #1 b.start = 1'b0;
    lat = 0;
    while (!b.done && lat < 2000) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("frac8 done latency", lat, 1280);
    chk("frac8 sat", int'(b.sat_flag), 0);
    check_out("frac8", b.output_tensor_flat, 16'h0400, 16'h0600, 16'h0900, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
